// File: rtl/uart_rx_core_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_core_pkg
//   Shared definitions for the UART receive path.
//   - rx_state_t : receiver FSM state encoding (3 bits, shared with TX tooling)
//   - OVS_MID    : oversample tick index at the centre of the start bit
//   - OVS_LAST   : oversample tick index that ends one bit period
// -----------------------------------------------------------------------------
package uart_rx_core_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam logic [3:0] OVS_MID  = 4'd7;
    localparam logic [3:0] OVS_LAST = 4'd15;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchroniser for an asynchronous, idle-high serial line.
//   Both flops reset to 1 so a line held in reset never looks like a start bit.
// Ports:
//   CLK    in  system clock
//   RST_N  in  synchronous active-low reset
//   D      in  asynchronous input
//   Q      out synchronised copy of D (2 CLK latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= D;
            sync_p1 <= sync_p0;
        end
    end

    assign Q = sync_p1;

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   UART receive engine driven by a 16x-baud tick. Detects start bits with a
//   mid-bit glitch check, samples each data bit at its centre, optionally
//   checks parity, checks the stop bit and presents one word per frame.
// Parameters:
//   DATA_BITS   data bits per frame (5..8), LSB first on the line
//   PARITY_EN   1 = one parity bit follows the data bits
//   PARITY_ODD  1 = odd parity, 0 = even parity
// Ports:
//   CLK          in   system clock
//   RST_N        in   synchronous active-low reset
//   BAUD_X16_EN  in   1-CLK tick at 16x baud rate
//   RXD          in   asynchronous serial input, idle high
//   RX_DATA      out  last received word, held until the next frame completes
//   RX_DATA_RDY  out  1-CLK pulse when RX_DATA / FRM_ERR / PAR_ERR update
//   FRM_ERR      out  stop bit sampled low in the last frame
//   PAR_ERR      out  parity mismatch in the last frame
//   RX_BUSY      out  receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BAUD_X16_EN,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_DATA_RDY,
    output logic                 FRM_ERR,
    output logic                 PAR_ERR,
    output logic                 RX_BUSY
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       ODD_SEL  = (PARITY_ODD != 0);

    logic                 rxd_s;
    rx_state_t            state_q, state_d;
    logic [3:0]           ov_cnt_q, ov_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 commit;

    uart_rx_sync u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (RXD),
        .Q     (rxd_s)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            ov_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            RX_DATA     <= '0;
            RX_DATA_RDY <= 1'b0;
            FRM_ERR     <= 1'b0;
            PAR_ERR     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ov_cnt_q    <= ov_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            RX_DATA_RDY <= commit;
            if (commit) begin
                RX_DATA <= shift_q;
                FRM_ERR <= ~rxd_s;
                PAR_ERR <= (PARITY_EN != 0) ? par_err_q : 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ov_cnt_d  = ov_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        commit    = 1'b0;

        if (BAUD_X16_EN) begin
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d  = START;
                        ov_cnt_d = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit later; a short low pulse
                    // is treated as noise and dropped without any flags.
                    if (ov_cnt_q == OVS_MID) begin
                        ov_cnt_d  = '0;
                        bit_cnt_d = '0;
                        state_d   = rxd_s ? IDLE : DATA;
                    end else begin
                        ov_cnt_d = ov_cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    // Counter was zeroed at start-bit centre, so wrapping at
                    // OVS_LAST lands on the centre of each data bit.
                    ov_cnt_d = ov_cnt_q + 4'd1;
                    if (ov_cnt_q == OVS_LAST) begin
                        shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    ov_cnt_d = ov_cnt_q + 4'd1;
                    if (ov_cnt_q == OVS_LAST) begin
                        par_err_d = ((^shift_q) ^ rxd_s) != ODD_SEL;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    ov_cnt_d = ov_cnt_q + 4'd1;
                    if (ov_cnt_q == OVS_LAST) begin
                        commit  = 1'b1;
                        // Returning to IDLE mid stop bit lets the next start
                        // edge be caught with no inter-frame gap.
                        state_d = rxd_s ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    // Hold off until the line goes high so a long low level
                    // is not mistaken for a stream of start bits.
                    if (rxd_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign RX_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_en = 1'b0;
    logic [1:0] tick_div = 2'd0;
    logic       rxd;
    logic       rxd_p;

    logic [7:0] rx_data,  rx_data_p;
    logic       rdy,      rdy_p;
    logic       frm_err,  frm_err_p;
    logic       par_err,  par_err_p;
    logic       busy,     busy_p;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_data[$];
    logic       got_frm[$];
    logic       got_par[$];
    logic [7:0] gotp_data[$];
    logic       gotp_frm[$];
    logic       gotp_par[$];

    always #4 clk = ~clk;

    // 16x tick: one CLK in every four.
    always @(negedge clk) begin
        tick_div = tick_div + 2'd1;
        baud_en  = (tick_div == 2'd0);
    end

    uart_rx_core #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .BAUD_X16_EN (baud_en),
        .RXD         (rxd),
        .RX_DATA     (rx_data),
        .RX_DATA_RDY (rdy),
        .FRM_ERR     (frm_err),
        .PAR_ERR     (par_err),
        .RX_BUSY     (busy)
    );

    uart_rx_core #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .CLK         (clk),
        .RST_N       (rst_n),
        .BAUD_X16_EN (baud_en),
        .RXD         (rxd_p),
        .RX_DATA     (rx_data_p),
        .RX_DATA_RDY (rdy_p),
        .FRM_ERR     (frm_err_p),
        .PAR_ERR     (par_err_p),
        .RX_BUSY     (busy_p)
    );

    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            got_data.push_back(rx_data);
            got_frm.push_back(frm_err);
            got_par.push_back(par_err);
        end
        if (rdy_p === 1'b1) begin
            gotp_data.push_back(rx_data_p);
            gotp_frm.push_back(frm_err_p);
            gotp_par.push_back(par_err_p);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rxd_p = v;
        else     rxd   = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic idle_bits(input bit sel, input int n);
        for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (use_par) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        rxd_p = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_data",  32'(rx_data), 32'h0);
        check("rst_rdy",   32'(rdy),     32'h0);
        check("rst_frm",   32'(frm_err), 32'h0);
        check("rst_par",   32'(par_err), 32'h0);
        check("rst_busy",  32'(busy),    32'h0);
        check("rst_busy_p", 32'(busy_p), 32'h0);

        rst_n = 1'b1;
        idle_bits(0, 2);

        // 1) 0xA5, 8N1, good stop
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("t1_count", 32'(got_data.size()), 32'd1);
        check("t1_data",  32'(got_data[0]),     32'hA5);
        check("t1_frm",   32'(got_frm[0]),      32'h0);
        check("t1_par",   32'(got_par[0]),      32'h0);
        check("t1_busy",  32'(busy),            32'h0);

        // 2) 20-CLK glitch while idle
        rxd = 1'b0;
        repeat (12) @(negedge clk);
        check("t2_busy_start", 32'(busy), 32'h1);
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (64) @(negedge clk);
        check("t2_busy_end", 32'(busy), 32'h0);
        check("t2_count",    32'(got_data.size()), 32'd1);

        // 3) 0x3C with low stop, line held low 5 bits, then released
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        repeat (3) drive_bit(0, 1'b0);
        check("t3_busy_break", 32'(busy), 32'h1);
        drive_bit(0, 1'b0);
        check("t3_count", 32'(got_data.size()), 32'd2);
        check("t3_data",  32'(got_data[1]),     32'h3C);
        check("t3_frm",   32'(got_frm[1]),      32'h1);
        idle_bits(0, 2);
        check("t3_no_second", 32'(got_data.size()), 32'd2);
        check("t3_busy_idle", 32'(busy), 32'h0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("t3_next_count", 32'(got_data.size()), 32'd3);
        check("t3_next_data",  32'(got_data[2]),     32'h5A);
        check("t3_next_frm",   32'(got_frm[2]),      32'h0);

        // 5) back-to-back frames, no gap
        send_frame(0, 8'h01, 0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1);
        send_frame(0, 8'h80, 0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("t5_count", 32'(got_data.size()), 32'd6);
        check("t5_d0",    32'(got_data[3]),     32'h01);
        check("t5_d1",    32'(got_data[4]),     32'hFF);
        check("t5_d2",    32'(got_data[5]),     32'h80);
        check("t5_frm2",  32'(got_frm[5]),      32'h0);

        // 6) reset during bit 4 of 0x55
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, ((8'h55 >> i) & 8'h01) != 0);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_data",  32'(rx_data), 32'h0);
        check("t6_rdy",   32'(rdy),     32'h0);
        check("t6_frm",   32'(frm_err), 32'h0);
        check("t6_par",   32'(par_err), 32'h0);
        check("t6_busy",  32'(busy),    32'h0);
        rst_n = 1'b1;
        idle_bits(0, 10);
        check("t6_no_rdy", 32'(got_data.size()), 32'd6);
        send_frame(0, 8'h12, 0, 1'b0, 1'b1);
        idle_bits(0, 1);
        check("t6_count", 32'(got_data.size()), 32'd7);
        check("t6_next",  32'(got_data[6]),     32'h12);

        // 4) even parity on the parity-enabled instance
        send_frame(1, 8'h07, 1, 1'b1, 1'b1);
        idle_bits(1, 1);
        send_frame(1, 8'h07, 1, 1'b0, 1'b1);
        idle_bits(1, 1);
        check("t4_count", 32'(gotp_data.size()), 32'd2);
        check("t4_data0", 32'(gotp_data[0]),     32'h07);
        check("t4_par0",  32'(gotp_par[0]),      32'h0);
        check("t4_frm0",  32'(gotp_frm[0]),      32'h0);
        check("t4_data1", 32'(gotp_data[1]),     32'h07);
        check("t4_par1",  32'(gotp_par[1]),      32'h1);
        check("t4_main_quiet", 32'(got_data.size()), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
